phase_marker_tx: RTL
====================

# phase_marker_tx

Synthesizable transmitter for the phase-marker protocol consumed by the ROB sync monitor. The block accepts phase requests (phase, start/end) from a fuzzing stimulus controller, encodes each into the 32-bit marker instruction word, and buffers it. It presents the words on a valid/ready port that drives an injection slot in front of the core's instruction stream, stamping each word with a sequence id. It also tracks which phases are open and flags protocol violations.

## Interface

Parameters:
- DEPTH, 4, marker FIFO entries (power of two, ≥2)
- ID_W, 16, width of the marker sequence id

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  phase request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_phase  in  3  0=VCTM 1=DELAY 2=TEXE 3=LEAK 4=INIT 5=BIM 6=TRAIN; 7 illegal
- req_end  in  1  0=START, 1=END
- out_valid  out  1  marker word available
- out_ready  in  1  injection slot consumes the word
- out_inst  out  32  encoded marker instruction
- out_id  out  ID_W  sequence id of the word on out_inst
- open_mask  out  7  bit p set while phase p is open (START sent, END not yet sent)
- err  out  1  one-cycle pulse on a protocol violation

## Operation

- Encoding: imm = 2*req_phase + req_end (12 bits, zero-extended); out_inst = {imm, 5'd0, 3'b010, 5'd0, 7'h13}. Examples: VCTM START = 32'h00002013, DELAY END = 32'h00302013, TRAIN END = 32'h00d02013.
- Accept: req_ready = !full. A request with req_phase==7 is consumed (handshake completes) but not enqueued; err pulses.
- FIFO: in-order, DEPTH entries. The head is presented on out_inst and out_valid. It pops on out_valid && out_ready.
- out_id: a counter that resets to 0 and increments by 1 on every pop, wrapping modulo 2^ID_W. out_id always shows the id of the current head.
- Phase tracking is updated at enqueue, not at pop. START sets open_mask[p]; END clears it.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged. When the FIFO is full, push is refused even if a pop occurs in the same cycle.
- Reset, including mid-operation: FIFO is flushed, counts and id are zeroed, open_mask is cleared. In-flight words are discarded and not replayed.

## Timing

- Reset values: req_ready=1, out_valid=0, out_inst=32'h0, out_id=0, open_mask=0, err=0.
- Latency from request accept to out_valid is 1 cycle when the FIFO is empty. There is no combinational path from req_* to out_*.
- out_inst and out_id hold stable while out_valid && !out_ready.
- req_ready depends only on state, with no combinational path from out_ready.
- open_mask and err update in the cycle after the accepting edge.
- Full throughput: one marker per cycle when out_ready is held high.

## Configuration

- PHASE_MARKER_CHECK_EN defined: ordering checks are active. A START for an already-open phase and an END for a closed phase each raise an err pulse. The word is still enqueued and open_mask is still updated.
- PHASE_MARKER_CHECK_EN undefined: the checks are removed, and err pulses only for req_phase==7. open_mask is still maintained.

## Structure

- Package phase_marker_pkg contains:
  - a phase enum (VCTM..TRAIN)
  - constants MARKER_OPCODE=7'h13, MARKER_FUNCT3=3'b010, NUM_PHASES=7
  - function encode_marker(phase, is_end) returning the 32-bit word
- Sub-module marker_fifo: parameterized DEPTH×(32) synchronous FIFO with registered head, full/empty flags, async active-high reset. The top level holds the accept logic, phase tracker, checker and id counter.

## Test plan

- Reset, then VCTM START with out_ready=1 → next cycle out_valid=1, out_inst=32'h00002013, out_id=0; after pop, out_id=1 and open_mask=7'b0000001.
- out_ready=0, 5 back-to-back requests with DEPTH=4 → 4 accepted, req_ready=0 on the 5th; release out_ready → words emerge in order with ids 0..3 and no duplicates.
- req_phase=7 → handshake completes, err pulses for 1 cycle, nothing enqueued, out_valid stays 0.
- With PHASE_MARKER_CHECK_EN: LEAK END while LEAK is closed → err pulses and 32'h00702013 is still emitted; LEAK START twice → err on the second request.
- Full FIFO with a pop and push in the same cycle → the push is refused, the pop completes, and req_ready=1 the following cycle.
- Assert reset with 3 words queued and DELAY open → out_valid=0, open_mask=0, out_id=0 immediately (async); the first word after deassert carries id 0.

Source files
------------

// File: rtl/phase_marker_pkg.sv
// Shared types and encoding helpers for the phase-marker transmitter.
package phase_marker_pkg;

    typedef enum logic [2:0] {
        VCTM  = 3'd0,
        DELAY = 3'd1,
        TEXE  = 3'd2,
        LEAK  = 3'd3,
        INIT  = 3'd4,
        BIM   = 3'd5,
        TRAIN = 3'd6
    } phase_e;

    localparam logic [6:0]  MARKER_OPCODE = 7'h13;
    localparam logic [2:0]  MARKER_FUNCT3 = 3'b010;
    localparam int unsigned NUM_PHASES    = 7;

    // Marker is an I-type op with rd=rs1=x0; imm carries {phase, is_end}.
    function automatic logic [31:0] encode_marker(input phase_e phase, input logic is_end);
        logic [11:0] imm;
        imm = {8'd0, phase, is_end};
        return {imm, 5'd0, MARKER_FUNCT3, 5'd0, MARKER_OPCODE};
    endfunction

endpackage

// File: rtl/marker_fifo.sv
// In-order synchronous FIFO for marker words; head reads as zero when empty.
module marker_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/phase_marker_tx.sv
// Phase-marker transmitter: encodes phase requests, queues them, stamps ids, tracks open phases.
// Define PHASE_MARKER_CHECK_EN to flag START-while-open and END-while-closed ordering errors.
module phase_marker_tx
    import phase_marker_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_phase,
    input  logic            req_end,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [ID_W-1:0] out_id,
    output logic [6:0]      open_mask,
    output logic            err
);

    logic        full;
    logic        empty;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic        violation;
    logic [31:0] word;

    assign req_ready = !full;
    assign out_valid = !empty;
    assign accept    = req_valid && !full;
    assign legal     = (req_phase < 3'(NUM_PHASES));
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign word      = encode_marker(phase_e'(req_phase), req_end);

    always_comb begin
        violation = 1'b0;
`ifdef PHASE_MARKER_CHECK_EN
        if (legal) violation = req_end ? !open_mask[req_phase] : open_mask[req_phase];
`endif
    end

    marker_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .head      (out_inst),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            open_mask <= '0;
            err       <= 1'b0;
            out_id    <= '0;
        end else begin
            err <= accept && (!legal || violation);
            if (push) open_mask[req_phase] <= !req_end;
            if (pop)  out_id <= out_id + 1'b1;
        end
    end

endmodule
